// File: rtl/mem_stage_ctrl_pkg.sv
// Purpose: shared pipeline definitions for the MEM stage (command encodings, address base, FSM states).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_stage_ctrl_pkg;

    // MEM_CMD encodings; 2'b11 is also treated as "no access".
    localparam logic [1:0] MEM_CMD_NONE  = 2'b00;
    localparam logic [1:0] MEM_CMD_LOAD  = 2'b01;
    localparam logic [1:0] MEM_CMD_STORE = 2'b10;

    // Byte address where data memory starts in the effective address space.
    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_access(input logic [1:0] cmd);
        return (cmd == MEM_CMD_LOAD) || (cmd == MEM_CMD_STORE);
    endfunction

    // Rebase the effective address and force word alignment.
    function automatic logic [31:0] phys_addr(input logic [31:0] eff,
                                              input logic [31:0] base);
        return (eff - base) & ~32'd3;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_wb_reg.sv
// Purpose: MEM/WB pipeline register with a bubble input.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: i_bubble=1 loads a bubble (wb_en=0, mem_r_en=0, data fields hold).
// Ports: clk/rst (async active-low); i_bubble; i_* next-stage fields; o_* registered fields.
module mem_wb_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bubble,
    input  logic              i_wb_en,
    input  logic              i_mem_r_en,
    input  logic [31:0]       i_alu_res,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [4:0]        i_dst,
    input  logic [31:0]       i_pc,
    output logic              o_wb_en,
    output logic              o_mem_r_en,
    output logic [31:0]       o_alu_res,
    output logic [DATA_W-1:0] o_rdata,
    output logic [4:0]        o_dst,
    output logic [31:0]       o_pc
);

    logic              r_wb_en;
    logic              r_mem_r_en;
    logic [31:0]       r_alu_res;
    logic [DATA_W-1:0] r_rdata;
    logic [4:0]        r_dst;
    logic [31:0]       r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_alu_res  <= '0;
            r_rdata    <= '0;
            r_dst      <= '0;
            r_pc       <= '0;
        end else if (i_bubble) begin
            // Only the control bits are killed; data fields hold their last value.
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
        end else begin
            r_wb_en    <= i_wb_en;
            r_mem_r_en <= i_mem_r_en;
            r_alu_res  <= i_alu_res;
            r_rdata    <= i_rdata;
            r_dst      <= i_dst;
            r_pc       <= i_pc;
        end
    end

    assign o_wb_en    = r_wb_en;
    assign o_mem_r_en = r_mem_r_en;
    assign o_alu_res  = r_alu_res;
    assign o_rdata    = r_rdata;
    assign o_dst      = r_dst;
    assign o_pc       = r_pc;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM stage control - issues data memory requests, freezes the pipe until ack, feeds MEM/WB.
// Latency: non-access 1 cycle; load/store 2 cycles minimum (request cycle + ack cycle).
// Backpressure: freeze held from request until the mem_ack cycle; MEM/WB takes bubbles meanwhile.
// Ports: clk/rst (async active-low); *_MEM from EXE/MEM; mem_* data memory handshake;
//        freeze to IF/ID/EXE and EXE/MEM; *_WB registered MEM/WB outputs.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter int          DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_EN_MEM,
    input  logic [1:0]        MEM_CMD_MEM,
    input  logic [31:0]       ALU_res_MEM,
    input  logic [DATA_W-1:0] src2_val_MEM,
    input  logic [4:0]        Dst_MEM,
    input  logic [31:0]       PC_MEM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              freeze,
    output logic              WB_EN_WB,
    output logic              MEM_R_EN_WB,
    output logic [31:0]       ALU_res_WB,
    output logic [DATA_W-1:0] MEM_rdata_WB,
    output logic [4:0]        Dst_WB,
    output logic [31:0]       PC_WB
);

    mem_state_e r_state;
    mem_state_e w_next_state;
    logic       w_access;
    logic       w_req;
    logic       w_freeze;
    logic       w_wb_en;
    logic       w_mem_r_en;

    assign w_access = is_access(MEM_CMD_MEM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // mem_ack seen in IDLE falls through to the default (no effect), which also
    // covers a late ack arriving after a reset abandoned the access.
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_freeze     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_next_state = ST_WAIT;
                    w_req        = 1'b1;
                    w_freeze     = 1'b1;
                end
            end
            ST_WAIT: begin
                w_req    = 1'b1;
                // Dropping freeze in the ack cycle lets upstream advance at this edge,
                // so a following access re-enters WAIT with no idle cycle.
                w_freeze = !mem_ack;
                if (mem_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are forced quiet while reset is held.
    assign mem_req   = w_req & rst;
    assign freeze    = w_freeze & rst;
    assign mem_we    = (MEM_CMD_MEM == MEM_CMD_STORE);
    assign mem_addr  = phys_addr(ALU_res_MEM, ADDR_BASE);
    assign mem_wdata = src2_val_MEM;

    // Stores never write back a register.
    assign w_wb_en    = WB_EN_MEM && (MEM_CMD_MEM != MEM_CMD_STORE);
    assign w_mem_r_en = (MEM_CMD_MEM == MEM_CMD_LOAD);

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .i_bubble   (w_freeze),
        .i_wb_en    (w_wb_en),
        .i_mem_r_en (w_mem_r_en),
        .i_alu_res  (ALU_res_MEM),
        .i_rdata    (mem_rdata),
        .i_dst      (Dst_MEM),
        .i_pc       (PC_MEM),
        .o_wb_en    (WB_EN_WB),
        .o_mem_r_en (MEM_R_EN_WB),
        .o_alu_res  (ALU_res_WB),
        .o_rdata    (MEM_rdata_WB),
        .o_dst      (Dst_WB),
        .o_pc       (PC_WB)
    );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose: directed self-checking bench for mem_stage_ctrl.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: memory ack is scripted per scenario.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        WB_EN_MEM;
    logic [1:0]  MEM_CMD_MEM;
    logic [31:0] ALU_res_MEM;
    logic [31:0] src2_val_MEM;
    logic [4:0]  Dst_MEM;
    logic [31:0] PC_MEM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        freeze;
    logic        WB_EN_WB;
    logic        MEM_R_EN_WB;
    logic [31:0] ALU_res_WB;
    logic [31:0] MEM_rdata_WB;
    logic [4:0]  Dst_WB;
    logic [31:0] PC_WB;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl #(
        .ADDR_BASE (32'd1024),
        .DATA_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .WB_EN_MEM    (WB_EN_MEM),
        .MEM_CMD_MEM  (MEM_CMD_MEM),
        .ALU_res_MEM  (ALU_res_MEM),
        .src2_val_MEM (src2_val_MEM),
        .Dst_MEM      (Dst_MEM),
        .PC_MEM       (PC_MEM),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .freeze       (freeze),
        .WB_EN_WB     (WB_EN_WB),
        .MEM_R_EN_WB  (MEM_R_EN_WB),
        .ALU_res_WB   (ALU_res_WB),
        .MEM_rdata_WB (MEM_rdata_WB),
        .Dst_WB       (Dst_WB),
        .PC_WB        (PC_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; new inputs are applied right after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] cmd, input logic [31:0] alu, input logic [31:0] src2,
                         input logic [4:0] dst, input logic [31:0] pc, input logic wb_en);
        MEM_CMD_MEM  = cmd;
        ALU_res_MEM  = alu;
        src2_val_MEM = src2;
        Dst_MEM      = dst;
        PC_MEM       = pc;
        WB_EN_MEM    = wb_en;
    endtask

    initial begin
        int frz_cnt;
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        // A load is presented during reset: request and freeze must stay low.
        drive(2'b01, 32'd1028, 32'h0, 5'd1, 32'h40, 1'b1);
        #12;
        check_val("rst_req", {31'b0, mem_req}, 32'd0);
        check_val("rst_freeze", {31'b0, freeze}, 32'd0);
        check_val("rst_wb_en", {31'b0, WB_EN_WB}, 32'd0);
        check_val("rst_alu_wb", ALU_res_WB, 32'd0);
        check_val("rst_pc_wb", PC_WB, 32'd0);
        drive(2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Non-access: 1-cycle latency, freeze stays low, an ack in IDLE is ignored.
        drive(2'b00, 32'h5, 32'h0, 5'd3, 32'h100, 1'b1);
        mem_ack = 1'b1;
        #1;
        check_val("na_freeze", {31'b0, freeze}, 32'd0);
        check_val("na_req", {31'b0, mem_req}, 32'd0);
        step();
        mem_ack = 1'b0;
        #1;
        check_val("na_wb_en", {31'b0, WB_EN_WB}, 32'd1);
        check_val("na_alu_wb", ALU_res_WB, 32'd5);
        check_val("na_dst_wb", {27'b0, Dst_WB}, 32'd3);
        check_val("na_rden_wb", {31'b0, MEM_R_EN_WB}, 32'd0);
        check_val("na_pc_wb", PC_WB, 32'h100);
        check_val("na_idle_req", {31'b0, mem_req}, 32'd0);

        // Load, ack arrives after three frozen cycles.
        drive(2'b01, 32'd1028, 32'h0, 5'd5, 32'h104, 1'b1);
        #1;
        check_val("ld_req", {31'b0, mem_req}, 32'd1);
        check_val("ld_we", {31'b0, mem_we}, 32'd0);
        check_val("ld_addr", mem_addr, 32'd4);
        frz_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (freeze) frz_cnt++;
            step();
            check_val("ld_wait_req", {31'b0, mem_req}, 32'd1);
            check_val("ld_bubble", {31'b0, WB_EN_WB}, 32'd0);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        if (freeze) frz_cnt++;
        check_val("ld_freeze_cycles", frz_cnt, 32'd3);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 32'h108, 1'b0);
        #1;
        check_val("ld_rdata_wb", MEM_rdata_WB, 32'hDEAD_BEEF);
        check_val("ld_rden_wb", {31'b0, MEM_R_EN_WB}, 32'd1);
        check_val("ld_wb_en", {31'b0, WB_EN_WB}, 32'd1);
        check_val("ld_dst_wb", {27'b0, Dst_WB}, 32'd5);
        check_val("ld_pc_wb", PC_WB, 32'h104);
        check_val("ld_done_req", {31'b0, mem_req}, 32'd0);
        step();

        // Store with immediate ack: one frozen cycle, no write-back.
        drive(2'b10, 32'd1032, 32'd7, 5'd6, 32'h10C, 1'b1);
        #1;
        check_val("st_we", {31'b0, mem_we}, 32'd1);
        check_val("st_addr", mem_addr, 32'd8);
        check_val("st_wdata", mem_wdata, 32'd7);
        check_val("st_freeze1", {31'b0, freeze}, 32'd1);
        step();
        mem_ack = 1'b1;
        #1;
        check_val("st_ack_freeze", {31'b0, freeze}, 32'd0);
        check_val("st_ack_req", {31'b0, mem_req}, 32'd1);
        step();
        mem_ack = 1'b0;
        // Back-to-back: a load follows directly, then a store.
        drive(2'b01, 32'd1036, 32'h0, 5'd9, 32'h110, 1'b1);
        #1;
        check_val("st_wb_en", {31'b0, WB_EN_WB}, 32'd0);
        check_val("st_rden_wb", {31'b0, MEM_R_EN_WB}, 32'd0);
        check_val("st_alu_wb", ALU_res_WB, 32'd1032);
        check_val("b2b_ld_req", {31'b0, mem_req}, 32'd1);
        check_val("b2b_ld_addr", mem_addr, 32'd12);
        step();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_1234;
        #1;
        check_val("b2b_ld_ack_req", {31'b0, mem_req}, 32'd1);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        drive(2'b10, 32'd1040, 32'd9, 5'd10, 32'h114, 1'b1);
        #1;
        check_val("b2b_st_req", {31'b0, mem_req}, 32'd1);
        check_val("b2b_st_freeze", {31'b0, freeze}, 32'd1);
        check_val("b2b_ld_wb_en", {31'b0, WB_EN_WB}, 32'd1);
        check_val("b2b_ld_rdata", MEM_rdata_WB, 32'h0000_1234);
        step();
        check_val("b2b_st_wait_req", {31'b0, mem_req}, 32'd1);
        check_val("b2b_st_bubble", {31'b0, WB_EN_WB}, 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        drive(2'b11, 32'h0, 32'h0, 5'd0, 32'h118, 1'b0);
        #1;
        check_val("b2b_st_alu_wb", ALU_res_WB, 32'd1040);
        check_val("b2b_st_wb_en", {31'b0, WB_EN_WB}, 32'd0);
        check_val("cmd11_req", {31'b0, mem_req}, 32'd0);
        step();

        // Reset in the middle of WAIT, then a stray ack after release.
        drive(2'b01, 32'd1044, 32'h0, 5'd7, 32'h11C, 1'b1);
        step();
        check_val("rw_wait_req", {31'b0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check_val("rw_req", {31'b0, mem_req}, 32'd0);
        check_val("rw_freeze", {31'b0, freeze}, 32'd0);
        check_val("rw_wb_en", {31'b0, WB_EN_WB}, 32'd0);
        check_val("rw_alu_wb", ALU_res_WB, 32'd0);
        check_val("rw_dst_wb", {27'b0, Dst_WB}, 32'd0);
        step();
        drive(2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0BAD;
        #1;
        check_val("rw_stray_req", {31'b0, mem_req}, 32'd0);
        check_val("rw_stray_freeze", {31'b0, freeze}, 32'd0);
        step();
        mem_ack = 1'b0;
        #1;
        check_val("rw_post_wb_en", {31'b0, WB_EN_WB}, 32'd0);
        check_val("rw_post_rden", {31'b0, MEM_R_EN_WB}, 32'd0);
        check_val("rw_post_req", {31'b0, mem_req}, 32'd0);

        // Misaligned effective address: low bits cleared after rebasing.
        drive(2'b01, 32'd1027, 32'h0, 5'd2, 32'h120, 1'b1);
        #1;
        check_val("mis_addr", mem_addr, 32'd0);
        step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
        #1;
        check_val("mis_rden_wb", {31'b0, MEM_R_EN_WB}, 32'd1);
        check_val("mis_alu_wb", ALU_res_WB, 32'd1027);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
